// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller:
// active-low segment patterns, the hex decoder and counter width helpers.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the active-low {a,b,c,d,e,f,g} pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// Synchronises a raw button, debounces it and emits a one-cycle pulse on
// each accepted press. Release is debounced too but produces no pulse.
module btn_debounce_pulse
  import ssd_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = cnt_width(DB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreement in between restarts the qualification.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      pulse_q     <= level_q & ~level_dly_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment driver with shadowed data,
// leading-zero blanking and a debounced single-step button pulse.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 200000,
  parameter int DB_CYCLES   = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic                blank_lz,
  input  logic                load,
  input  logic                step_btn,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                seg_dp,
  output logic                step_pulse
);

  localparam int PW = cnt_width(REFRESH_DIV);
  localparam int IW = cnt_width(DIGITS);

  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q;
  logic [DIGITS-1:0]   sh_dp_q;
  logic                sh_lz_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   blank_vec;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;

  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PW'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero
  // while every nibble at or above it is zero. Digit 0 always stays lit.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (sh_data_q[4*k +: 4] == 4'h0);
      blank_vec[k] = sh_lz_q & zero_run & (k != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = sh_data_q[4*k +: 4];
        cur_dp    = sh_dp_q[k];
        cur_blank = blank_vec[k];
      end
    end
  end

  always_comb begin
    an_d     = ~(DIGITS'(1) << idx_q);
    seg_d    = hex_to_seg(cur_nib);
    seg_dp_d = ~cur_dp;
    if (cur_blank) begin
      an_d     = '1;
      seg_d    = SEG_BLANK;
      seg_dp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  // Shadow copies hold between loads so a frame never mixes two values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_lz_q   <= 1'b0;
    end else if (load) begin
      sh_data_q <= data;
      sh_dp_q   <= dp;
      sh_lz_q   <= blank_lz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
      seg_dp_q <= 1'b1;
    end else begin
      an_q     <= an_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;

  btn_debounce_pulse #(
    .DB_CYCLES(DB_CYCLES)
  ) u_step_btn (
    .clk_i  (clk),
    .rst_i  (reset),
    .btn_i  (step_btn),
    .pulse_o(step_pulse)
  );

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: directed display/button scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_ssd_scan_ctrl;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic        step_btn = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        step_pulse;

  int c_total = 0;
  int c_err   = 0;

  logic [6:0] seg_tab [16];

  // model state
  int          m_edges, m_run;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_lz, m_r1, m_r2, m_level, m_rise;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_pulse;

  logic [15:0] cur_data;
  logic [3:0]  cur_dp;
  logic        cur_lz;
  int          pulse_cnt;
  int          first_seen;
  int          hits;

  ssd_scan_ctrl #(
    .DIGITS(D),
    .REFRESH_DIV(RD),
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .dp        (dp),
    .blank_lz  (blank_lz),
    .load      (load),
    .step_btn  (step_btn),
    .an        (an),
    .seg       (seg),
    .seg_dp    (seg_dp),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    c_total++;
    if (obs !== exp) begin
      c_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_run   = 0;
    m_data  = '0;
    m_dp    = '0;
    m_lz    = 1'b0;
    m_r1    = 1'b0;
    m_r2    = 1'b0;
    m_level = 1'b0;
    m_rise  = 1'b0;
  endtask

  // Predicts outputs after the coming edge, then absorbs that edge's inputs.
  task automatic model_step(input logic ld, input logic b);
    int          k;
    logic        blanked;
    logic [15:0] upper;
    logic        synced;
    m_edges++;
    k       = ((m_edges - 1) / RD) % D;
    upper   = m_data >> (4 * k);
    blanked = m_lz && (k != 0) && (upper == 16'h0);
    exp_an  = blanked ? 4'hF : ~(4'b0001 << k);
    exp_seg = blanked ? 7'h7F : seg_tab[upper[3:0]];
    exp_dp  = blanked ? 1'b1 : ~m_dp[k];
    // a press is accepted after DB consecutive disagreeing synced samples
    exp_pulse = m_rise;
    m_rise    = 1'b0;
    synced    = m_r2;
    if (synced != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = synced;
        m_run   = 0;
        m_rise  = synced;
      end
    end else begin
      m_run = 0;
    end
    m_r2 = m_r1;
    m_r1 = b;
    if (ld) begin
      m_data = cur_data;
      m_dp   = cur_dp;
      m_lz   = cur_lz;
    end
  endtask

  task automatic cycle(input logic ld, input logic b);
    load     = ld;
    data     = cur_data;
    dp       = cur_dp;
    blank_lz = cur_lz;
    step_btn = b;
    model_step(ld, b);
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("seg_dp", 32'(seg_dp), 32'(exp_dp));
    chk("step_pulse", 32'(step_pulse), 32'(exp_pulse));
    if (step_pulse) pulse_cnt++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(seg_dp), 32'h1);
    chk({tag, "_pulse"}, 32'(step_pulse), 32'h0);
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    cur_data  = '0;
    cur_dp    = '0;
    cur_lz    = 1'b0;
    pulse_cnt = 0;
    model_reset();

    // clock/reset
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // hex value 12AF, no blanking
    cur_data = 16'h12AF; cur_dp = 4'b0000; cur_lz = 1'b0;
    cycle(1'b1, 1'b0);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0);
      if (an == 4'b1110) hits++;
      if (an == 4'b0111) chk("s1_seg_digit3", 32'(seg), 32'(7'b1001111));
      if (an == 4'b1110) chk("s1_seg_digit0", 32'(seg), 32'(7'b0111000));
    end
    chk("s1_digit0_slots", 32'(hits), 32'd4);

    // 0030 with leading-zero blanking
    cur_data = 16'h0030; cur_lz = 1'b1;
    cycle(1'b1, 1'b0);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0);
      if (an == 4'hF) hits++;
    end
    chk("s2_blank_slots", 32'(hits), 32'd8);

    // all-zero value shows only digit 0
    cur_data = 16'h0000; cur_lz = 1'b1;
    cycle(1'b1, 1'b0);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0);
      if (an == 4'b1110 && seg == 7'b0000001) hits++;
    end
    chk("s3_zero_lit_slots", 32'(hits), 32'd4);

    // decimal point on digit 2 only
    cur_data = 16'h5A5A; cur_dp = 4'b0100; cur_lz = 1'b0;
    cycle(1'b1, 1'b0);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0);
      if (seg_dp == 1'b0 && an == 4'b1011) hits++;
    end
    chk("s4_dp_slots", 32'(hits), 32'd4);

    // clean press held 20 cycles, then release
    repeat (12) cycle(1'b0, 1'b0);
    pulse_cnt  = 0;
    first_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b1);
      if (step_pulse && first_seen == 0) first_seen = i;
    end
    repeat (20) cycle(1'b0, 1'b0);
    chk("press_pulses", 32'(pulse_cnt), 32'd1);
    chk("press_latency", 32'(first_seen), 32'd11);

    // 3-cycle bounces never qualify
    pulse_cnt = 0;
    repeat (4) begin
      repeat (3) cycle(1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0);
    end
    repeat (12) cycle(1'b0, 1'b0);
    chk("bounce_pulses", 32'(pulse_cnt), 32'd0);

    // reset mid-frame and mid-debounce
    cur_data = 16'h12AF; cur_dp = 4'b1111; cur_lz = 1'b0;
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    step_btn = 1'b0;
    load     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("held_reset");
    reset = 1'b0;
    model_reset();
    pulse_cnt = 0;
    cycle(1'b0, 1'b0);
    chk("post_reset_an", 32'(an), 32'(4'b1110));
    chk("post_reset_seg", 32'(seg), 32'(7'b0000001));
    repeat (30) cycle(1'b0, 1'b0);
    chk("post_reset_pulses", 32'(pulse_cnt), 32'd0);

    // randomized traffic
    begin
      logic b;
      int   run_left;
      b = 1'b0;
      run_left = 0;
      for (int i = 0; i < 800; i++) begin
        logic ld;
        ld = ($urandom_range(0, 15) == 0);
        if (ld) begin
          cur_data = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
          cur_dp   = 4'($urandom_range(0, 15));
          cur_lz   = 1'($urandom_range(0, 1));
        end
        if (run_left == 0) begin
          b = ~b;
          run_left = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5) : $urandom_range(8, 16);
        end
        run_left--;
        cycle(ld, b);
      end
    end

    $display("Result: errors=%0d of %0d checks", c_err, c_total);
    $finish;
  end

endmodule
